tetris_frame_streamer: RTL and testbench

TETRIS_FRAME_STREAMER -- requirements
Module: tetris_frame_streamer

---
 rtl/tetris_frame_streamer_if.sv | 25 ++
 rtl/tetris_frame_streamer.sv | 154 +++++++++++++++
 tb/tb_tetris_frame_streamer.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_frame_streamer_if.sv
// Stream interface for the Tetris frame streamer.
//   out_data  : 16-bit stream word
//   out_valid : out_data holds a word the consumer may take
//   out_ready : consumer accepts the word this cycle
//   out_last  : current word is the final word of the frame
interface tetris_frame_streamer_if;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/tetris_frame_streamer.sv
// Tetris frame streamer: snapshots the game grid, score and status flags,
// then streams them as a fixed 22-word frame over a valid/ready interface.
//
// Frame layout:
//   word 0      : {HDR_TAG, game_over, game_paused, row_cleared, 1'b0, frame_count}
//   words 1..20 : {6'b0, row r}, r = 0..19
//   word 21     : {2'b00, score}
//
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   grid_state[199:0]  : live grid, cell (r,c) at bit r*10+c
//   score[13:0]        : live score
//   game_over          : game-over level
//   game_paused        : pause level
//   row_cleared        : row-cleared level or pulse (made sticky here)
//   frame_req          : start one frame when idle
//   strm               : stream master (out_data/out_valid/out_last/out_ready)
//   busy               : a frame is in progress
//   dirty              : live grid differs from the last snapshot (one-cycle lag)
//   frame_count[7:0]   : completed frames, mod 256
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for frame_req (or dirty grid when AUTO_SEND=1)
// SEND  | presenting snapshot words 0..21, advancing on each transfer
module tetris_frame_streamer #(
  parameter bit         AUTO_SEND = 1'b0,
  parameter logic [3:0] HDR_TAG   = 4'hA
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [199:0]                   grid_state,
  input  logic [13:0]                    score,
  input  logic                           game_over,
  input  logic                           game_paused,
  input  logic                           row_cleared,
  input  logic                           frame_req,
  tetris_frame_streamer_if.master        strm,
  output logic                           busy,
  output logic                           dirty,
  output logic [7:0]                     frame_count
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'd21;

  state_t       state;
  state_t       state_nxt;
  logic         start;
  logic         xfer;
  logic         last_word;
  logic [4:0]   word_idx;
  logic [4:0]   row_sel;
  logic [7:0]   row_base;
  logic [15:0]  data;

  logic [199:0] snap_grid;
  logic [13:0]  snap_score;
  logic         snap_over;
  logic         snap_paused;
  logic         snap_row;
  logic         row_sticky;

  assign last_word = (word_idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (frame_req || (AUTO_SEND && dirty)) begin
          start     = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        xfer = strm.out_ready;
        if (xfer && last_word) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_idx    <= '0;
      frame_count <= '0;
      snap_grid   <= '0;
      snap_score  <= '0;
      snap_over   <= 1'b0;
      snap_paused <= 1'b0;
      snap_row    <= 1'b0;
      row_sticky  <= 1'b0;
      dirty       <= 1'b1;
    end else begin
      // A pulse coinciding with the start edge goes into this frame's header
      // instead of the sticky flag, so it is reported exactly once.
      row_sticky <= start ? 1'b0 : (row_sticky | row_cleared);
      dirty      <= start ? 1'b0 : (grid_state != snap_grid);
      if (start) begin
        snap_grid   <= grid_state;
        snap_score  <= score;
        snap_over   <= game_over;
        snap_paused <= game_paused;
        snap_row    <= row_sticky | row_cleared;
        word_idx    <= '0;
      end else if (xfer) begin
        if (last_word) begin
          word_idx    <= '0;
          frame_count <= frame_count + 8'd1;
        end else begin
          word_idx <= word_idx + 5'd1;
        end
      end
    end
  end

  // Row words are indexed from word 1, so row r sits at word r+1.
  always_comb begin
    row_sel  = word_idx - 5'd1;
    row_base = {3'b000, row_sel} * 8'd10;
    data     = '0;
    if (state == SEND) begin
      if (word_idx == 5'd0) begin
        data = {HDR_TAG, snap_over, snap_paused, snap_row, 1'b0, frame_count};
      end else if (last_word) begin
        data = {2'b00, snap_score};
      end else begin
        data = {6'b000000, snap_grid[row_base +: 10]};
      end
    end
  end

  assign strm.out_data  = data;
  assign strm.out_valid = (state == SEND);
  assign strm.out_last  = (state == SEND) && last_word;
  assign busy           = (state == SEND);

endmodule

// File: tb/tb_tetris_frame_streamer.sv
module tb_tetris_frame_streamer;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic [199:0] grid_state;
  logic [13:0]  score;
  logic         game_over;
  logic         game_paused;
  logic         row_cleared;
  logic         frame_req;
  logic         busy;
  logic         dirty;
  logic [7:0]   frame_count;
  logic         a_busy;
  logic         a_dirty;
  logic [7:0]   a_frame_count;

  tetris_frame_streamer_if s_if ();
  tetris_frame_streamer_if a_if ();

  tetris_frame_streamer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .grid_state  (grid_state),
    .score       (score),
    .game_over   (game_over),
    .game_paused (game_paused),
    .row_cleared (row_cleared),
    .frame_req   (frame_req),
    .strm        (s_if.master),
    .busy        (busy),
    .dirty       (dirty),
    .frame_count (frame_count)
  );

  tetris_frame_streamer #(.AUTO_SEND(1'b1)) dut_auto (
    .clk         (clk),
    .reset_n     (reset_n),
    .grid_state  (grid_state),
    .score       (score),
    .game_over   (game_over),
    .game_paused (game_paused),
    .row_cleared (row_cleared),
    .frame_req   (1'b0),
    .strm        (a_if.master),
    .busy        (a_busy),
    .dirty       (a_dirty),
    .frame_count (a_frame_count)
  );

  typedef struct {
    logic [199:0] grid;
    logic [13:0]  score;
    logic         over;
    logic         paused;
    logic [15:0]  w0;
    logic [15:0]  w1;
    logic [15:0]  w2;
    logic [15:0]  w20;
    logic [15:0]  w21;
  } vec_t;

  vec_t        vecs [3];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] words [22];
  logic        lasts [22];
  int          nwords;
  int          ncyc;
  int          stall_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input string tag);
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    chk({tag, "_valid_rise"}, {31'd0, s_if.out_valid}, 32'd1);
  endtask

  // Collect 22 transfers; optionally random ready, grid change after
  // change_at words, and a one-cycle frame_req after req_at words.
  task automatic recv_frame(input bit rand_ready, input int change_at,
                            input logic [199:0] new_grid, input int req_at);
    logic        prev_stall;
    logic [15:0] prev_data;
    logic        prev_last;
    nwords     = 0;
    ncyc       = 0;
    stall_err  = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    while (nwords < 22 && ncyc < 400) begin
      if (nwords == change_at) grid_state = new_grid;
      if (req_at >= 0) frame_req = (nwords == req_at);
      s_if.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_if.out_valid) begin
        if (prev_stall && (s_if.out_data !== prev_data || s_if.out_last !== prev_last))
          stall_err++;
        if (s_if.out_ready) begin
          words[nwords] = s_if.out_data;
          lasts[nwords] = s_if.out_last;
          nwords++;
        end
        prev_stall = !s_if.out_ready;
        prev_data  = s_if.out_data;
        prev_last  = s_if.out_last;
      end else begin
        prev_stall = 1'b0;
      end
      tick();
      ncyc++;
    end
    s_if.out_ready = 1'b1;
    if (req_at >= 0) frame_req = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [199:0] g,
                             input logic [13:0] sc, input logic [15:0] hdr);
    int bad = 0;
    int badlast = 0;
    chk({tag, "_count"}, nwords, 22);
    chk({tag, "_hdr"}, {16'd0, words[0]}, {16'd0, hdr});
    for (int r = 0; r < 20; r++)
      if (words[r+1] !== {6'b000000, g[r*10 +: 10]}) bad++;
    chk({tag, "_rows"}, bad, 0);
    chk({tag, "_score"}, {16'd0, words[21]}, {18'd0, sc});
    for (int i = 0; i < 22; i++)
      if (lasts[i] !== (i == 21)) badlast++;
    chk({tag, "_last"}, badlast, 0);
    chk({tag, "_idle_after"}, {31'd0, s_if.out_valid}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [199:0] g2;
  logic [199:0] g_old;
  logic [199:0] g_new;
  int           seen;
  int           lat;
  int           nlast;
  logic [7:0]   base_fc;

  initial begin
    vecs[0] = '{grid: (200'd1 | (200'd1 << 199)), score: 14'd1234, over: 1'b0, paused: 1'b0,
                w0: 16'hA000, w1: 16'h0001, w2: 16'h0000, w20: 16'h0200, w21: 16'h04D2};
    vecs[1] = '{grid: (200'h3FF << 10), score: 14'h3FFF, over: 1'b1, paused: 1'b0,
                w0: 16'hA801, w1: 16'h0000, w2: 16'h03FF, w20: 16'h0000, w21: 16'h3FFF};
    vecs[2] = '{grid: (200'h155 | (200'h2AA << 190)), score: 14'd0, over: 1'b1, paused: 1'b1,
                w0: 16'hAC02, w1: 16'h0155, w2: 16'h0000, w20: 16'h02AA, w21: 16'h0000};
    g2    = {8{25'h1A5F0C3}};
    g_old = {20{10'h0F3}};
    g_new = {20{10'h30C}};

    reset_n        = 1'b0;
    grid_state     = '0;
    score          = '0;
    game_over      = 1'b0;
    game_paused    = 1'b0;
    row_cleared    = 1'b0;
    frame_req      = 1'b0;
    s_if.out_ready = 1'b1;
    a_if.out_ready = 1'b1;

    #12;
    chk("rst_valid", {31'd0, s_if.out_valid}, 32'd0);
    chk("rst_last", {31'd0, s_if.out_last}, 32'd0);
    chk("rst_data", {16'd0, s_if.out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fc", {24'd0, frame_count}, 32'd0);
    chk("rst_dirty", {31'd0, dirty}, 32'd1);
    tick();
    reset_n = 1'b1;

    // Table-driven frames with ready held high.
    for (int i = 0; i < 3; i++) begin
      grid_state  = vecs[i].grid;
      score       = vecs[i].score;
      game_over   = vecs[i].over;
      game_paused = vecs[i].paused;
      start_frame($sformatf("v%0d", i));
      recv_frame(1'b0, -1, '0, -1);
      chk($sformatf("v%0d_cycles", i), ncyc, 22);
      chk($sformatf("v%0d_w0", i), {16'd0, words[0]}, {16'd0, vecs[i].w0});
      chk($sformatf("v%0d_w1", i), {16'd0, words[1]}, {16'd0, vecs[i].w1});
      chk($sformatf("v%0d_w2", i), {16'd0, words[2]}, {16'd0, vecs[i].w2});
      chk($sformatf("v%0d_w20", i), {16'd0, words[20]}, {16'd0, vecs[i].w20});
      chk($sformatf("v%0d_w21", i), {16'd0, words[21]}, {16'd0, vecs[i].w21});
      check_frame($sformatf("v%0d", i), vecs[i].grid, vecs[i].score, vecs[i].w0);
      chk($sformatf("v%0d_fc", i), {24'd0, frame_count}, i + 1);
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd0);
    end
    game_over   = 1'b0;
    game_paused = 1'b0;

    // Random stalls, plus a frame_req mid-frame that must not queue.
    grid_state = g2;
    score      = 14'd9999;
    start_frame("stall");
    recv_frame(1'b1, -1, '0, 5);
    check_frame("stall", g2, 14'd9999, 16'hA003);
    chk("stall_stable", stall_err, 0);
    seen = 0;
    repeat (5) begin
      tick();
      if (s_if.out_valid) seen++;
    end
    chk("req_not_queued", seen, 0);

    // Row-cleared pulse while idle, then a frame without a pulse.
    row_cleared = 1'b1;
    tick();
    row_cleared = 1'b0;
    tick();
    start_frame("rc1");
    recv_frame(1'b0, -1, '0, -1);
    check_frame("rc1", g2, 14'd9999, 16'hA204);
    start_frame("rc2");
    recv_frame(1'b0, -1, '0, -1);
    check_frame("rc2", g2, 14'd9999, 16'hA005);

    // Row-cleared on the start edge itself.
    row_cleared = 1'b1;
    start_frame("rc3");
    row_cleared = 1'b0;
    recv_frame(1'b0, -1, '0, -1);
    check_frame("rc3", g2, 14'd9999, 16'hA206);
    start_frame("rc4");
    recv_frame(1'b0, -1, '0, -1);
    check_frame("rc4", g2, 14'd9999, 16'hA007);

    // Grid change during SEND with frame_req held high.
    grid_state = g_old;
    score      = 14'd77;
    frame_req  = 1'b1;
    tick();
    chk("s4_valid_rise", {31'd0, s_if.out_valid}, 32'd1);
    recv_frame(1'b0, 8, g_new, -1);
    check_frame("s4_old", g_old, 14'd77, 16'hA008);
    chk("s4_dirty_between", {31'd0, dirty}, 32'd1);
    chk("s4_busy_between", {31'd0, busy}, 32'd0);
    tick();
    frame_req = 1'b0;
    chk("s4_restart", {31'd0, s_if.out_valid}, 32'd1);
    recv_frame(1'b0, -1, '0, -1);
    check_frame("s4_new", g_new, 14'd77, 16'hA009);
    chk("s4_dirty_clean", {31'd0, dirty}, 32'd0);

    // Auto-send instance: static grid gives no frames, one flip gives one.
    repeat (60) tick();
    base_fc = a_frame_count;
    chk("auto_dirty_static", {31'd0, a_dirty}, 32'd0);
    seen = 0;
    repeat (40) begin
      tick();
      if (a_busy) seen++;
    end
    chk("auto_static_none", seen, 0);
    chk("auto_static_fc", {24'd0, a_frame_count}, {24'd0, base_fc});
    grid_state[57] = ~grid_state[57];
    lat = 0;
    while (!a_busy && lat < 10) begin
      tick();
      lat++;
    end
    chk("auto_latency", {31'd0, (lat >= 1 && lat <= 2)}, 32'd1);
    repeat (60) tick();
    chk("auto_one_frame", {24'd0, a_frame_count}, {24'd0, base_fc + 8'd1});

    // 256 back-to-back frames after reset: frame_count wraps.
    reset_n = 1'b0;
    #1;
    chk("rst2_fc", {24'd0, frame_count}, 32'd0);
    tick();
    reset_n   = 1'b1;
    frame_req = 1'b1;
    nlast     = 0;
    ncyc      = 0;
    while (nlast < 256 && ncyc < 7000) begin
      automatic logic pend = s_if.out_valid && s_if.out_last && s_if.out_ready;
      tick();
      ncyc++;
      if (pend) begin
        nlast++;
        if (nlast == 255) chk("wrap_fc255", {24'd0, frame_count}, 32'd255);
      end
    end
    frame_req = 1'b0;
    chk("wrap_frames", nlast, 256);
    chk("wrap_fc0", {24'd0, frame_count}, 32'd0);

    // Reset asserted at word 10 aborts the frame immediately.
    start_frame("abort");
    repeat (10) tick();
    chk("abort_w10", {16'd0, s_if.out_data}, {22'd0, grid_state[90 +: 10]});
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_valid", {31'd0, s_if.out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_data", {16'd0, s_if.out_data}, 32'd0);
    chk("abort_fc", {24'd0, frame_count}, 32'd0);
    chk("abort_dirty", {31'd0, dirty}, 32'd1);
    tick();
    reset_n = 1'b1;
    seen = 0;
    repeat (5) begin
      tick();
      if (s_if.out_valid) seen++;
    end
    chk("abort_no_words", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
